fft_frame_ctrl: RTL
===================

Name: fft_frame_ctrl

Overview:
Frame scheduler for the 1024-point streaming FFT core. It accepts samples from upstream with a valid/ready handshake and drives the core's `enable` and `data_in`. It tracks the core's fixed pipeline latency, counted in enabled cycles, and flushes the pipeline with zero samples on stop. It marks the core output stream with valid, start-of-frame and end-of-frame flags, and asserts valid only for frames built from real input.

Parameters:
- WORDLENGTH, 32, sample width (packed re/im), matches the core.
- FRAME_LEN, 1024, samples per FFT frame; power of two.
- LATENCY, 7168, enabled cycles from first sample accepted into the core to first output sample (7 RAM levels x 1024).
- CNTW, 16, width of the frame counters.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset. Synchronous, active-high.
- start, input, 1, one-cycle pulse; begin a session (honoured in IDLE only).
- stop, input, 1, one-cycle pulse; end the session at the next frame boundary, then flush.
- in_valid, input, 1, upstream sample valid.
- in_ready, output, 1, controller accepts a sample this cycle.
- in_data, input, WORDLENGTH, upstream sample.
- fft_enable, output, 1, core advance strobe.
- fft_data_in, output, WORDLENGTH, sample to core.
- fft_data_out, input, WORDLENGTH, core output.
- out_valid, output, 1, out_data holds a real FFT output sample.
- out_sof, output, 1, first sample of an output frame (qualified by out_valid).
- out_eof, output, 1, last sample of an output frame (qualified by out_valid).
- out_data, output, WORDLENGTH, equals fft_data_out (combinational pass-through).
- busy, output, 1, state is not IDLE.
- frames_in, output, CNTW, complete real frames accepted this session.
- frames_out, output, CNTW, complete frames emitted this session.

Behaviour:
- **States.** IDLE, RUN, FLUSH. Encoded registered; all outputs below are derived from state.
- **Reset.**
  - state=IDLE.
  - in_ready=0, fft_enable=0, out_valid=0, out_sof=0, out_eof=0, busy=0.
  - All counters 0 and stop_pend=0.
  - A reset mid-operation abandons the session with no flush.
- **IDLE.**
  - in_ready=0, fft_enable=0.
  - start -> RUN. On entry: in_cnt, lat_cnt, out_cnt, frames_in and frames_out cleared.
  - stop is ignored.
- **RUN.**
  - in_ready=1.
  - fft_enable = in_valid (combinational).
  - fft_data_in = in_data.
  - Gaps in in_valid freeze the core; no data is lost.
  - start is ignored.
  - stop sets stop_pend. A stop arriving in the same cycle as a frame-completing accept counts as a stop at that boundary.
- **Stop evaluation** (each cycle in RUN when stop_pend=1 or stop=1, at a boundary where in_cnt==0 after any accept):
  - frames_in==frames_out -> IDLE.
  - otherwise -> FLUSH.
  - stop_pend is cleared on leaving RUN.
- **FLUSH.**
  - in_ready=0, fft_enable=1 every cycle, fft_data_in=0.
  - -> IDLE on the cycle frames_out increments to equal frames_in.
- **Accept counting.** in_cnt increments on each accept and wraps FRAME_LEN-1 -> 0. On the wrap, frames_in increments.
- **Latency counting.**
  - lat_cnt increments on each fft_enable cycle and saturates at LATENCY.
  - An enabled cycle is "productive" when lat_cnt==LATENCY at that cycle (before increment) and frames_out<frames_in. frames_in includes a frame completed in the same cycle.
- **Output flags.**
  - out_valid is registered: set the cycle after a productive enabled cycle (the core's registered output is present then), 0 otherwise.
  - out_cnt counts productive cycles and wraps at FRAME_LEN.
  - out_sof is registered, =1 with out_valid when out_cnt was 0.
  - out_eof is registered, =1 when out_cnt was FRAME_LEN-1; frames_out increments on that same edge.
- **Partial frames.**
  - A partial input frame at stop cannot occur, because stop waits for the boundary.
  - Output frames are always contiguous, with no partial frame.
- **Counters.** Counter overflow at 2^CNTW wraps. Sessions are required to be shorter than this.
- **Second session.** After FLUSH the core pipeline holds zeros. The next session's first output again appears after LATENCY enabled cycles (lat_cnt cleared on start).

Test Plan:
- FRAME_LEN=16, LATENCY=112; start, 3 frames with continuous in_valid, stop at sample 47 -> FLUSH; 48 out_valid cycles, first one on the cycle after enabled cycle 113; out_sof at out_cnt 0/16/32, out_eof at 15/31/47; frames_out=3; then IDLE with busy=0.
- Same, with in_valid toggling 1/0 -> fft_enable mirrors in_valid in RUN; outputs identical in content and order; out_valid gaps track the fft_enable gaps.
- stop pulse at in_cnt=5 of frame 2 -> RUN continues to the boundary (frames_in=2), then FLUSH; exactly 32 valid outputs; in_ready=0 throughout FLUSH.
- start then stop before any accept -> IDLE immediately at the next cycle; no fft_enable, no out_valid.
- rst asserted mid-FLUSH -> next cycle state=IDLE and all outputs/counters 0; a subsequent start produces first out_valid after 112 enabled cycles.
- start pulsed during RUN, stop pulsed in IDLE -> both ignored; counters unchanged.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler for the streaming FFT core: gates core enables, flushes on stop
// and flags the output stream with valid/sof/eof once the pipeline latency has elapsed.
module fft_frame_ctrl #(
    parameter int WORDLENGTH = 32,
    parameter int FRAME_LEN  = 1024,
    parameter int LATENCY    = 7168,
    parameter int CNTW       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDLENGTH-1:0] in_data,
    output logic                  fft_enable,
    output logic [WORDLENGTH-1:0] fft_data_in,
    input  logic [WORDLENGTH-1:0] fft_data_out,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [WORDLENGTH-1:0] out_data,
    output logic                  busy,
    output logic [CNTW-1:0]       frames_in,
    output logic [CNTW-1:0]       frames_out,
    output logic [1:0]            dbg_state
);

    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int LW = $clog2(LATENCY + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);
    localparam logic [LW-1:0] LAT    = LW'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Handshake: a sample moves when in_valid && in_ready on a rising clk edge;
    // in_ready is high exactly in RUN and never depends on in_valid.
    state_t          state_q, state_d;
    logic [FW-1:0]   in_cnt_q, in_cnt_d;
    logic [FW-1:0]   out_cnt_q, out_cnt_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [CNTW-1:0] frames_in_q, frames_in_d;
    logic [CNTW-1:0] frames_out_q, frames_out_d;
    logic            stop_pend_q, stop_pend_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eof_q, out_eof_d;

    logic accept;
    logic in_wrap;
    logic productive;
    logic out_wrap;
    logic stop_req;

    always_comb begin
        accept      = (state_q == S_RUN) && in_valid;
        fft_enable  = accept || (state_q == S_FLUSH);
        fft_data_in = (state_q == S_RUN) ? in_data : '0;
        in_wrap     = accept && (in_cnt_q == F_LAST);
        stop_req    = stop || stop_pend_q;

        in_cnt_d    = in_cnt_q;
        if (accept) begin
            in_cnt_d = in_wrap ? '0 : in_cnt_q + FW'(1);
        end
        frames_in_d = frames_in_q + CNTW'(in_wrap);

        lat_cnt_d = lat_cnt_q;
        if (fft_enable && (lat_cnt_q != LAT)) begin
            lat_cnt_d = lat_cnt_q + LW'(1);
        end

        // A frame completing this cycle already counts as real input.
        productive   = fft_enable && (lat_cnt_q == LAT) && (frames_out_q < frames_in_d);
        out_wrap     = productive && (out_cnt_q == F_LAST);
        out_cnt_d    = out_cnt_q;
        if (productive) begin
            out_cnt_d = out_wrap ? '0 : out_cnt_q + FW'(1);
        end
        frames_out_d = frames_out_q + CNTW'(out_wrap);
        out_valid_d  = productive;
        out_sof_d    = productive && (out_cnt_q == '0);
        out_eof_d    = out_wrap;

        state_d     = state_q;
        stop_pend_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    in_cnt_d     = '0;
                    lat_cnt_d    = '0;
                    out_cnt_d    = '0;
                    frames_in_d  = '0;
                    frames_out_d = '0;
                end
            end
            S_RUN: begin
                stop_pend_d = stop_req;
                if (stop_req && (in_cnt_d == '0)) begin
                    stop_pend_d = 1'b0;
                    state_d     = (frames_in_d == frames_out_d) ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_wrap && (frames_out_d == frames_in_q)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            frames_in_q  <= '0;
            frames_out_q <= '0;
            stop_pend_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            frames_in_q  <= frames_in_d;
            frames_out_q <= frames_out_d;
            stop_pend_q  <= stop_pend_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign in_ready   = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign out_data   = fft_data_out;
    assign frames_in  = frames_in_q;
    assign frames_out = frames_out_q;
    assign dbg_state  = state_q;

endmodule
